// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   Multi-cycle sequencer for a LEGv8 datapath. Each instruction is fetched
//   over a shared instruction/data memory port with a ready handshake. The
//   instruction-register opcode is then decoded, and the datapath is stepped
//   through per-class states. Supported instructions are ADD/SUB/AND/ORR,
//   LDUR, STUR and CBZ. Any other opcode parks the unit in a sticky TRAP
//   state. A retired-instruction counter is also maintained.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   OpCode[10:0]    IR bits [31:21]
//   Zero            ALU zero flag (CBZ outcome)
//   mem_ready       memory completes the current read/write this cycle
//   PCWrite..Branch datapath strobes and selects (all forced to 0 in reset)
//   illegal         unsupported opcode trapped
//   state[3:0]      current state encoding
//   retired         retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      OpCode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             Reg2Loc,
    output logic [1:0]       AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       Aluop,
    output logic             PCSource,
    output logic             Branch,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_LD  = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    // Opcode classes. The R-type pattern 1xx0101x000 covers ADD/SUB/AND/ORR.
    logic is_r, is_ld, is_st, is_cbz;
    assign is_r   = OpCode[10] && (OpCode[7:4] == 4'b0101) && (OpCode[2:0] == 3'b000);
    assign is_ld  = (OpCode == 11'b11111000010);
    assign is_st  = (OpCode == 11'b11111000000);
    assign is_cbz = (OpCode[10:3] == 8'b10110100);

    // Next-state and retire logic
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_r)               state_d = S_EXEC_R;
                else if (is_ld || is_st) state_d = S_ADDR;
                else if (is_cbz)        state_d = S_BRANCH;
                else                    state_d = S_TRAP;
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   begin state_d = S_FETCH; retire = 1'b1; end
            S_ADDR:   state_d = is_ld ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
            S_WB_LD:  begin state_d = S_FETCH; retire = 1'b1; end
            S_MEM_WR: if (mem_ready) begin state_d = S_FETCH; retire = 1'b1; end
            S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        illegal_d = illegal_q || (state_d == S_TRAP);
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Output decode. It is a Moore function of state_q, except for three
    // cases: the FETCH handshake strobes, the CBZ PCWrite, and Reg2Loc.
    // Reset gates everything combinationally, so an access in flight is
    // dropped in the same cycle that rst rises.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        Reg2Loc  = 1'b0;
        AluSrcA  = 2'b00;
        AluSrcB  = 2'b00;
        Aluop    = 2'b00;
        PCSource = 1'b0;
        Branch   = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            Reg2Loc = (state_q != S_TRAP) && (is_st || is_cbz);
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    AluSrcB = 2'b01;
                    PCWrite = mem_ready;
                    IRWrite = mem_ready;
                end
                S_DECODE: begin
                    // Branch target = OldPC + (imm << 2), parked in ALUOut
                    AluSrcA = 2'b10;
                    AluSrcB = 2'b11;
                end
                S_EXEC_R: begin
                    AluSrcA = 2'b01;
                    Aluop   = 2'b10;
                end
                S_WB_R:   RegWrite = 1'b1;
                S_ADDR: begin
                    AluSrcA = 2'b01;
                    AluSrcB = 2'b10;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_WB_LD: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BRANCH: begin
                    // Pass regB through the ALU; Zero selects the PC load
                    AluSrcA  = 2'b01;
                    Aluop    = 2'b01;
                    Branch   = 1'b1;
                    PCSource = 1'b1;
                    PCWrite  = Zero;
                end
                S_TRAP:   illegal = illegal_q;
                default:  ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   OpCode;
    logic          Zero;
    logic          mem_ready;
    logic          PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic          RegWrite, Reg2Loc, PCSource, Branch, illegal;
    logic [1:0]    AluSrcA, AluSrcB, Aluop;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    multicycle_control_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .Reg2Loc(Reg2Loc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .Aluop(Aluop),
        .PCSource(PCSource), .Branch(Branch), .illegal(illegal), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // {state, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite,
    //  Reg2Loc, AluSrcA, AluSrcB, Aluop, PCSource, Branch, illegal}
    logic [20:0] vec;
    assign vec = {state, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg,
                  RegWrite, Reg2Loc, AluSrcA, AluSrcB, Aluop, PCSource, Branch, illegal};

    typedef struct packed {
        logic        rdy;
        logic [20:0] exp;
    } ent_t;

    ent_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [10:0]   cur_op;
    logic          cur_z;
    logic [CW-1:0] exp_ret;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_LD  = 11'b11111000010;
    localparam logic [10:0] OP_ST  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ = 11'b10110100101;
    localparam logic [10:0] OP_BAD = 11'b00000000000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected outputs for one cycle, written out from the state table.
    function automatic logic [20:0] ev(input logic [3:0] st, input logic rdy,
                                       input logic z, input logic [10:0] op);
        logic pcw, irw, iord, mr, mw, m2r, rw, r2l, pcs, br, ill;
        logic [1:0] sa, sbs, ao;
        {pcw, irw, iord, mr, mw, m2r, rw, r2l, pcs, br, ill} = '0;
        sa = 2'b00; sbs = 2'b00; ao = 2'b00;
        r2l = (st != 4'd9) && ((op == 11'b11111000000) || (op[10:3] == 8'b10110100));
        case (st)
            4'd0: begin mr = 1; sbs = 2'b01; pcw = rdy; irw = rdy; end
            4'd1: begin sa = 2'b10; sbs = 2'b11; end
            4'd2: begin sa = 2'b01; ao = 2'b10; end
            4'd3: rw = 1;
            4'd4: begin sa = 2'b01; sbs = 2'b10; end
            4'd5: begin mr = 1; iord = 1; end
            4'd6: begin rw = 1; m2r = 1; end
            4'd7: begin mw = 1; iord = 1; end
            4'd8: begin sa = 2'b01; ao = 2'b01; br = 1; pcs = 1; pcw = z; end
            4'd9: ill = 1;
            default: ;
        endcase
        return {st, pcw, irw, iord, mr, mw, m2r, rw, r2l, sa, sbs, ao, pcs, br, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy);
        ent_t e;
        e.rdy = rdy;
        e.exp = ev(st, rdy, cur_z, cur_op);
        sb.push_back(e);
    endtask

    // One cycle: entered #1 after a rising edge, drives inputs, samples mid-cycle.
    task automatic step(input logic rdy, input logic [20:0] exp, input string tag);
        rst = 1'b0;
        mem_ready = rdy;
        #3;
        chk(tag, {11'b0, vec}, {11'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e.rdy, e.exp, tag);
        end
    endtask

    task automatic do_reset(input int n, input logic [3:0] cur_state);
        logic [3:0] s;
        s = cur_state;
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            mem_ready = 1'b1;
            #3;
            chk("rst_out", {11'b0, vec}, {11'b0, s, 17'b0});
            @(posedge clk);
            #1;
            s = 4'd0;
        end
        chk("rst_state", {28'b0, state}, 32'd0);
        chk("rst_retired", {{(32-CW){1'b0}}, retired}, 32'd0);
        exp_ret = '0;
    endtask

    task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                             input logic z, input string tag);
        logic bad;
        cur_op = op; cur_z = z; OpCode = op; Zero = z;
        bad = 1'b0;
        for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        push(4'd1, 1'($urandom_range(0, 1)));
        if (op == OP_LD) begin
            push(4'd4, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) push(4'd5, 1'b0);
            push(4'd5, 1'b1);
            push(4'd6, 1'($urandom_range(0, 1)));
        end else if (op == OP_ST) begin
            push(4'd4, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mw; i++) push(4'd7, 1'b0);
            push(4'd7, 1'b1);
        end else if (op[10:3] == 8'b10110100) begin
            push(4'd8, 1'($urandom_range(0, 1)));
        end else if (op[10] && op[7:4] == 4'b0101 && op[2:0] == 3'b000) begin
            push(4'd2, 1'($urandom_range(0, 1)));
            push(4'd3, 1'($urandom_range(0, 1)));
        end else begin
            bad = 1'b1;
            for (int i = 0; i < 20; i++) push(4'd9, 1'($urandom_range(0, 1)));
        end
        drain(tag);
        if (!bad) exp_ret = exp_ret + 1'b1;
        chk({tag, "_retired"}, {{(32-CW){1'b0}}, retired}, {{(32-CW){1'b0}}, exp_ret});
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; OpCode = OP_ADD; Zero = 1'b0;
        cur_op = OP_ADD; cur_z = 1'b0; exp_ret = '0;
        @(posedge clk);
        #1;
        do_reset(2, 4'd0);

        run_instr(OP_ADD, 0, 0, 1'b0, "add");
        run_instr(OP_SUB, 1, 0, 1'b1, "sub");
        run_instr(OP_AND, 0, 0, 1'b0, "and");
        run_instr(OP_ORR, 0, 0, 1'b0, "orr");
        run_instr(OP_LD,  2, 2, 1'b0, "ldur");
        run_instr(OP_LD,  0, 0, 1'b1, "ldur0");
        run_instr(OP_ST,  1, 1, 1'b0, "stur");
        run_instr(OP_ST,  0, 0, 1'b1, "stur0");
        run_instr(OP_CBZ, 0, 0, 1'b1, "cbz_t");
        run_instr(OP_CBZ, 0, 0, 1'b0, "cbz_nt");

        // Illegal opcode: trap for 20 cycles, then reset out of TRAP
        run_instr(OP_BAD, 0, 0, 1'b0, "trap");
        do_reset(1, 4'd9);
        run_instr(OP_ADD, 0, 0, 1'b0, "add_after_trap");

        // Reset while a store waits on memory
        cur_op = OP_ST; cur_z = 1'b0; OpCode = OP_ST;
        push(4'd0, 1'b1);
        push(4'd1, 1'b0);
        push(4'd4, 1'b0);
        push(4'd7, 1'b0);
        push(4'd7, 1'b0);
        drain("st_partial");
        do_reset(1, 4'd7);

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++)
            run_instr(OP_CBZ, 0, 0, 1'(i % 2), "wrap_cbz");
        chk("wrap_final", {{(32-CW){1'b0}}, retired}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
